// File: rtl/cacheline_burst_adaptor.sv
// Purpose: turns one 256-bit cache line read/write into a 4-beat 64-bit memory burst.
// Latency: request seen in IDLE at T, burst from T+1, resp_o one cycle after the last beat.
// Backpressure: memory paces the burst with resp_i (gaps stall it); requester holds its request until resp_o.
module cacheline_burst_adaptor #(
    parameter int BURST_W = 64,
    parameter int BEATS   = 4,
    parameter int ADDR_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [BURST_W*BEATS-1:0]   line_i,
    output logic [BURST_W*BEATS-1:0]   line_o,
    input  logic [ADDR_W-1:0]          address_i,
    input  logic                       read_i,
    input  logic                       write_i,
    output logic                       resp_o,
    input  logic [BURST_W-1:0]         burst_i,
    output logic [BURST_W-1:0]         burst_o,
    output logic [ADDR_W-1:0]          address_o,
    output logic                       read_o,
    output logic                       write_o,
    input  logic                       resp_i
);

    localparam int LINE_W = BURST_W * BEATS;
    localparam int CNT_W  = $clog2(BEATS);
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_W / 8 - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BURST_W-1:0]  beat_dat;

    // The line buffer doubles as read assembly buffer and latched write line.
    assign line_o = line_q;

    // Select the write slice addressed by the beat counter.
    always_comb begin
        beat_dat = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (CNT_W'(b) == cnt_q) begin
                beat_dat = line_q[b*BURST_W +: BURST_W];
            end
        end
    end

    // Next-state, datapath updates and Moore outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        addr_d    = addr_q;
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        burst_o   = '0;
        address_o = '0;
        case (state_q)
            IDLE: begin
                // Read wins when both requests are present.
                if (read_i) begin
                    addr_d  = address_i & ALIGN_MASK;
                    cnt_d   = '0;
                    state_d = RD_BURST;
                end else if (write_i) begin
                    addr_d  = address_i & ALIGN_MASK;
                    line_d  = line_i;
                    cnt_d   = '0;
                    state_d = WR_BURST;
                end
            end
            RD_BURST: begin
                read_o    = 1'b1;
                address_o = addr_q;
                if (resp_i) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (CNT_W'(b) == cnt_q) begin
                            line_d[b*BURST_W +: BURST_W] = burst_i;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RD_DONE;
                    end
                end
            end
            RD_DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end
            WR_BURST: begin
                write_o   = 1'b1;
                address_o = addr_q;
                burst_o   = beat_dat;
                if (resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = WR_DONE;
                    end
                end
            end
            WR_DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
- Memory-side responder for the cache's physical-memory line interface: accepts one 256-bit line read or write per request and answers with a single-cycle response.
- Converts each line request into a 4-beat, 64-bit burst on the external memory bus (burst initiator side).
- Sits between the cache (or arbiter) line port and main memory.

Parameters:
BURST_W, 64, width of one burst beat in bits
BEATS, 4, beats per line; LINE_W = BURST_W*BEATS = 256
ADDR_W, 32, address width

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
line_i  input  256  write line from cache
line_o  output  256  assembled read line; valid when resp_o=1
address_i  input  32  line request address
read_i  input  1  line read request; held until resp_o
write_i  input  1  line write request; held until resp_o
resp_o  output  1  one-cycle completion pulse
burst_i  input  64  read beat from memory
burst_o  output  64  write beat to memory
address_o  output  32  burst address, line-aligned
read_o  output  1  burst read request
write_o  output  1  burst write request
resp_i  input  1  memory beat handshake, one per beat

Behaviour:
- One clock; reset synchronous, active-low. Sampled reset_n=0 -> next edge: state IDLE, beat counter 0, line buffer 0, latched address 0. All outputs 0 (line_o, burst_o, address_o, resp_o, read_o, write_o).
- Reset mid-burst: abort immediately, same values; no resp_o is issued for the aborted request.
- States: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- IDLE: read_i=1 -> latch {address_i[31:5],5'b0}, go RD_BURST. Else write_i=1 -> latch address, latch line_i, go WR_BURST. If both are 1, read wins; write_i is then ignored for that request.
- RD_BURST: read_o=1, address_o=latched address. Each cycle with resp_i=1 stores burst_i into line buffer slice [64*k+63:64*k], where k is the beat counter (beat 0 = bits 63:0). Counter then increments.
- resp_i=0 cycles are gaps: no capture, no increment.
- The cycle that captures beat 3 is the last cycle with read_o=1; next state RD_DONE.
- RD_DONE: resp_o=1 for exactly one cycle, line_o=assembled line, then IDLE.
- WR_BURST: write_o=1, address_o=latched address, burst_o = latched line slice k.
- Each resp_i=1 cycle accepts beat k and increments the counter; burst_o updates to slice k+1 on the next cycle.
- The cycle accepting beat 3 is the last cycle with write_o=1; next state WR_DONE.
- WR_DONE: resp_o=1 for one cycle, then IDLE.
- Requests are sampled only in IDLE. read_i, write_i, address_i and line_i changes during a burst are ignored; line_i is captured only at acceptance.
- The requester drops its request after resp_o, so the cycle after DONE sees IDLE with the request low; no spurious second transaction.
- Back-to-back requests: a new request presented in the first IDLE cycle after DONE is accepted there.
- Counter is 2 bits and wraps 3->0 at burst end; it is 0 on every burst start.
- Latency, no gaps: request seen in IDLE at cycle T; read_o/write_o high from T+1. If memory answers beats at T+1..T+4, resp_o=1 at T+5.
- line_o holds the last assembled line outside resp_o. Its value is only guaranteed while resp_o=1.
- read_o and write_o are never high in the same cycle. resp_o is never high in RD_BURST or WR_BURST.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles during a write burst after beat 1 -> all outputs 0, state IDLE, no resp_o; a following read completes normally.
- Read, no gaps: address_i=0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220, read_o high 4 cycles, resp_o at T+5, line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
- Read with gaps: resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 captures in order, resp_o one cycle after the 7th pattern cycle, read_o high for all 7 cycles.
- Write: line_i=0xDEAD..._CAFE (256 bits) at 0x8000_0040; change line_i mid-burst -> burst_o carries the original slices 0..3 in order, write_o drops after beat 3, resp_o one cycle later.
- Read and write both asserted in IDLE -> read_o=1, write_o=0 throughout; single resp_o.
- Back-to-back read then write, request re-presented the cycle after resp_o -> second transaction starts there; no duplicate or lost resp_o.
